// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding,
// lock-loss counter width and a small constant helper.
package reset_seq_pkg;

  // State encoding matches the status register block (WAIT_LOCK=0 .. HOLD=3)
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2,
    ST_HOLD      = 2'd3
  } seq_state_e;

  localparam int LOCK_CNT_W = 8;

  // Largest of three constants, used to size the shared timer
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable down-counter with a done flag. Counts down to zero and parks
// there; a load always wins over the decrement.
module reset_seq_timer #(
  parameter int           W       = 6,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Count register: reset to RST_VAL, load on request, else decrement to zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/reset_seq.sv
// Board-level reset sequencer: filters PLL lock, then releases NUM_DOMAINS
// reset lines in index order with a fixed gap; soft-reset requests re-run
// the release after a hold period.
// Optional build macro RESET_SEQ_LOCK_CNT_EN adds the lock_loss_cnt_o port
// and its saturating lock-loss counter.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS  = 4,
  parameter int LOCK_FILTER  = 8,
  parameter int DELAY_CYCLES = 16,
  parameter int HOLD_CYCLES  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   locked_i,
  input  logic                   sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   ready_o,
  output logic                   sw_rst_ack_o
`ifdef RESET_SEQ_LOCK_CNT_EN
  ,
  output logic [LOCK_CNT_W-1:0]  lock_loss_cnt_o
`endif
);

  localparam int TW = $clog2(max3(LOCK_FILTER, DELAY_CYCLES, HOLD_CYCLES) + 1);
  localparam int IW = $clog2(NUM_DOMAINS) + 1;

  // Timer reload values. The timer fires one cycle after reaching zero, so
  // gaps are loaded as N-1. The entry into RELEASE from the lock filter is
  // loaded with the full gap so that bit0 falls LOCK_FILTER+DELAY_CYCLES
  // cycles after the first locked sample.
  localparam logic [TW-1:0] LF_LOAD    = TW'(LOCK_FILTER - 1);
  localparam logic [TW-1:0] FIRST_LOAD = TW'(DELAY_CYCLES);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);

  seq_state_e             r_state, w_state_next;
  logic [NUM_DOMAINS-1:0] r_rst, w_rst_next;
  logic [IW-1:0]          r_idx, w_idx_next;
  logic                   r_ready, w_ready_next;
  logic                   r_ack, w_ack_next;
  logic                   r_soft, w_soft_next;
  logic                   w_load;
  logic [TW-1:0]          w_load_val;
  logic                   w_done;
  logic                   w_lost;
  logic                   w_last;
  logic [NUM_DOMAINS-1:0] w_idx_hot;

  reset_seq_timer #(
    .W       (TW),
    .RST_VAL (LF_LOAD)
  ) u_timer (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // One-hot decode of the domain currently being released
  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_idx_hot
    assign w_idx_hot[gi] = (r_idx == IW'(gi));
  end

  assign w_last = (r_idx == IW'(NUM_DOMAINS - 1));
  // Losing lock anywhere past the filter restarts from scratch
  assign w_lost = (r_state != ST_WAIT_LOCK) && !locked_i;

  // State and output registers; rst_i aborts any sequence immediately
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_WAIT_LOCK;
      r_rst   <= '1;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_ack   <= 1'b0;
      r_soft  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rst   <= w_rst_next;
      r_idx   <= w_idx_next;
      r_ready <= w_ready_next;
      r_ack   <= w_ack_next;
      r_soft  <= w_soft_next;
    end
  end

  // Next-state logic: lock loss has priority over everything, including a
  // soft-reset request seen on the same cycle
  always_comb begin
    w_state_next = r_state;
    w_rst_next   = r_rst;
    w_idx_next   = r_idx;
    w_ready_next = 1'b0;
    w_ack_next   = 1'b0;
    w_soft_next  = r_soft;
    w_load       = 1'b0;
    w_load_val   = LF_LOAD;
    if (w_lost) begin
      w_state_next = ST_WAIT_LOCK;
      w_rst_next   = '1;
      w_idx_next   = '0;
      w_soft_next  = 1'b0;
      w_load       = 1'b1;
      w_load_val   = LF_LOAD;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          if (!locked_i) begin
            w_load     = 1'b1;
            w_load_val = LF_LOAD;
          end else if (w_done) begin
            w_state_next = ST_RELEASE;
            w_idx_next   = '0;
            w_load       = 1'b1;
            w_load_val   = FIRST_LOAD;
          end
        end
        ST_RELEASE: begin
          if (w_done) begin
            w_rst_next = r_rst & ~w_idx_hot;
            if (w_last) begin
              w_state_next = ST_RUN;
            end else begin
              w_idx_next = r_idx + IW'(1);
              w_load     = 1'b1;
              w_load_val = GAP_LOAD;
            end
          end
        end
        ST_RUN: begin
          if (sw_rst_req_i) begin
            w_state_next = ST_HOLD;
            w_rst_next   = '1;
            w_idx_next   = '0;
            w_soft_next  = 1'b1;
            w_load       = 1'b1;
            w_load_val   = HOLD_LOAD;
          end else begin
            w_ready_next = 1'b1;
            w_ack_next   = r_soft;
            w_soft_next  = 1'b0;
          end
        end
        ST_HOLD: begin
          if (w_done) begin
            w_state_next = ST_RELEASE;
            w_load       = 1'b1;
            w_load_val   = GAP_LOAD;
          end
        end
        default: begin
          w_state_next = ST_WAIT_LOCK;
          w_rst_next   = '1;
        end
      endcase
    end
  end

  assign rst_o        = r_rst;
  assign ready_o      = r_ready;
  assign sw_rst_ack_o = r_ack;

`ifdef RESET_SEQ_LOCK_CNT_EN
  logic [LOCK_CNT_W-1:0] r_loss_cnt;

  // Saturating count of lock-loss events; only rst_i clears it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_loss_cnt <= '0;
    end else if (w_lost && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + LOCK_CNT_W'(1);
    end
  end

  assign lock_loss_cnt_o = r_loss_cnt;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq. The reference model tracks release
// times as absolute cycle stamps (anchor + k*gap) rather than counters.
// Build with RESET_SEQ_LOCK_CNT_EN to also check the lock-loss counter.
module tb_reset_seq;

  localparam int N  = 4;
  localparam int LF = 8;
  localparam int D  = 16;
  localparam int H  = 32;

  localparam int M_WAIT = 0;
  localparam int M_ACT  = 1;
  localparam int M_HOLD = 2;

  logic         clk;
  logic         rst_i;
  logic         locked_i;
  logic         sw_rst_req_i;
  logic [N-1:0] rst_o;
  logic         ready_o;
  logic         sw_rst_ack_o;
`ifdef RESET_SEQ_LOCK_CNT_EN
  logic [7:0]   lock_loss_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state
  int           m_mode       = M_WAIT;
  int           m_run_start  = -1;
  int           m_anchor     = 0;
  int           m_hold_start = 0;
  bit           m_soft       = 1'b0;
  int           m_cnt        = 0;
  logic [N-1:0] e_rst        = '1;
  logic         e_ready      = 1'b0;
  logic         e_ack        = 1'b0;

  int n_ack;

  reset_seq #(
    .NUM_DOMAINS  (N),
    .LOCK_FILTER  (LF),
    .DELAY_CYCLES (D),
    .HOLD_CYCLES  (H)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .locked_i     (locked_i),
    .sw_rst_req_i (sw_rst_req_i),
    .rst_o        (rst_o),
    .ready_o      (ready_o),
    .sw_rst_ack_o (sw_rst_ack_o)
`ifdef RESET_SEQ_LOCK_CNT_EN
    ,
    .lock_loss_cnt_o (lock_loss_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic lose_lock();
    m_mode      = M_WAIT;
    m_run_start = -1;
    m_soft      = 1'b0;
    if (m_cnt < 255) m_cnt++;
    e_rst   = '1;
    e_ready = 1'b0;
  endtask

  // Expected outputs after the edge at which (r, lk, rq) were sampled
  task automatic model_step(input bit r, input bit lk, input bit rq);
    int last;
    e_ack = 1'b0;
    if (r) begin
      m_mode = M_WAIT; m_run_start = -1; m_soft = 1'b0; m_cnt = 0;
      e_rst = '1; e_ready = 1'b0;
      return;
    end
    if (m_mode == M_WAIT) begin
      e_rst = '1; e_ready = 1'b0;
      if (lk) begin
        if (m_run_start < 0) m_run_start = cyc;
        if (cyc - m_run_start + 1 >= LF) begin
          m_mode   = M_ACT;
          m_anchor = m_run_start + LF + D;
        end
      end else begin
        m_run_start = -1;
      end
    end else if (!lk) begin
      lose_lock();
    end else if (m_mode == M_HOLD) begin
      e_rst = '1; e_ready = 1'b0;
      if (cyc == m_hold_start + H) begin
        m_mode   = M_ACT;
        m_anchor = cyc + D;
      end
    end else begin
      last = m_anchor + D * (N - 1);
      if (cyc > last && rq) begin
        m_mode = M_HOLD; m_hold_start = cyc; m_soft = 1'b1;
        e_rst = '1; e_ready = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) e_rst[k] = (cyc >= m_anchor + D * k) ? 1'b0 : 1'b1;
        e_ready = (cyc > last);
        if (m_soft && cyc == last + 1) begin
          e_ack  = 1'b1;
          m_soft = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge
  task automatic step(input bit r, input bit lk, input bit rq);
    @(negedge clk);
    rst_i = r; locked_i = lk; sw_rst_req_i = rq;
    @(posedge clk);
    cyc++;
    model_step(r, lk, rq);
    #1;
    check("rst_o", 32'(rst_o), 32'(e_rst));
    check("ready_o", 32'(ready_o), 32'(e_ready));
    check("sw_rst_ack_o", 32'(sw_rst_ack_o), 32'(e_ack));
`ifdef RESET_SEQ_LOCK_CNT_EN
    check("lock_loss_cnt_o", 32'(lock_loss_cnt_o), 32'(m_cnt));
`endif
    if (sw_rst_ack_o) n_ack++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; locked_i = 1'b0; sw_rst_req_i = 1'b0;

    // Reset state
    do_reset();
    check("reset_rst_o", 32'(rst_o), 32'h0000000F);
    check("reset_ready", 32'(ready_o), 32'd0);
    $display("[tb] reset: rst_o=%b ready=%b", rst_o, ready_o);

    // Power-up: locked from cycle 0
    n_ack = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 23) check("pu_bit0_held", 32'(rst_o[0]), 32'd1);
      if (i == 24) check("pu_bit0_fall", 32'(rst_o[0]), 32'd0);
      if (i == 40) check("pu_bit1_fall", 32'(rst_o[1]), 32'd0);
      if (i == 56) check("pu_bit2_fall", 32'(rst_o[2]), 32'd0);
      if (i == 71) check("pu_bit3_held", 32'(rst_o[3]), 32'd1);
      if (i == 72) check("pu_ready_low", 32'(ready_o), 32'd0);
      if (i == 73) check("pu_ready_high", 32'(ready_o), 32'd1);
    end
    check("pu_no_ack", 32'(n_ack), 32'd0);
    $display("[tb] power-up sequence: rst_o=%b ready=%b", rst_o, ready_o);

    // Soft reset pulse from RUN
    n_ack = 0;
    step(1'b0, 1'b1, 1'b1);
    check("sw_all_ones", 32'(rst_o), 32'h0000000F);
    for (int j = 1; j <= 110; j++) begin
      step(1'b0, 1'b1, 1'b0);
      if (j == 47) check("sw_bit0_held", 32'(rst_o[0]), 32'd1);
      if (j == 48) check("sw_bit0_fall", 32'(rst_o[0]), 32'd0);
      if (j == 96) check("sw_ready_low", 32'(ready_o), 32'd0);
      if (j == 97) check("sw_ack_with_ready", 32'({ready_o, sw_rst_ack_o}), 32'd3);
    end
    check("sw_one_ack", 32'(n_ack), 32'd1);
    $display("[tb] soft reset: acks=%0d ready=%b", n_ack, ready_o);

    // Lock glitch restarts the filter
    do_reset();
    for (int i = 0; i < 41; i++) begin
      step(1'b0, (i != 5), 1'b0);
      if (i == 29) check("glitch_bit0_held", 32'(rst_o[0]), 32'd1);
      if (i == 30) check("glitch_bit0_fall", 32'(rst_o[0]), 32'd0);
    end
    $display("[tb] lock glitch: rst_o=%b", rst_o);

    // Lock loss mid-release
    do_reset();
    for (int i = 0; i < 45; i++) step(1'b0, 1'b1, 1'b0);
    check("ll_before", 32'(rst_o), 32'h0000000C);
    step(1'b0, 1'b0, 1'b0);
    check("ll_rst_o", 32'(rst_o), 32'h0000000F);
    check("ll_ready", 32'(ready_o), 32'd0);
`ifdef RESET_SEQ_LOCK_CNT_EN
    check("ll_cnt_one", 32'(lock_loss_cnt_o), 32'd1);
`endif
    $display("[tb] lock loss in release: rst_o=%b", rst_o);

    // Lock loss together with a soft-reset request in RUN
    do_reset();
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b0);
    n_ack = 0;
    step(1'b0, 1'b0, 1'b1);
    check("llsw_rst_o", 32'(rst_o), 32'h0000000F);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
    check("llsw_no_ack", 32'(n_ack), 32'd0);
    check("llsw_ready", 32'(ready_o), 32'd1);
    $display("[tb] lock loss beats soft reset: acks=%0d", n_ack);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 199) != 0),
           ($urandom_range(0, 49) == 0));
    end
    $display("[tb] random traffic: 3000 cycles");

    // rst_i mid-release, then 300 lock-loss events
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("abort_rst_o", 32'(rst_o), 32'h0000000F);
    check("abort_ready", 32'(ready_o), 32'd0);
    check("abort_ack", 32'(sw_rst_ack_o), 32'd0);
    for (int e = 0; e < 300; e++) begin
      for (int i = 0; i < LF; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
`ifdef RESET_SEQ_LOCK_CNT_EN
    check("cnt_saturated", 32'(lock_loss_cnt_o), 32'h000000FF);
`endif
    $display("[tb] abort and 300 lock losses: rst_o=%b", rst_o);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
